// File: rtl/seg_reader.sv
// Purpose : debounces sampled 7-segment patterns. Once a pattern has been seen STABLE_CNT
//           times in a row it is decoded into a digit and its pre-increment operand.
// Latency : outputs update on the edge that takes the accepting sample; out_valid pulses for the following cycle.
// Backpr. : none; seg_in is sampled on every cycle where seg_valid=1.
// Ports   : clk, rst (sync, active-high), seg_in[6:0] (active-low a..g), seg_valid ->
//           digit, orig, out_valid, blank, illegal, err_count.
module seg_reader #(
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       seg_valid,
    output logic [3:0] digit,
    output logic [3:0] orig,
    output logic       out_valid,
    output logic       blank,
    output logic       illegal,
    output logic [7:0] err_count
);

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [6:0] last_pat_q, last_pat_d;
    logic [3:0] run_q, run_d;
    logic [3:0] digit_q, digit_d;
    logic [3:0] orig_q, orig_d;
    logic       blank_q, blank_d;
    logic       illegal_q, illegal_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] err_q, err_d;

    // Decode of the current sample; only committed on acceptance.
    logic [3:0] dec_digit;
    logic [3:0] dec_orig;
    logic       dec_blank;
    logic       dec_illegal;

    always_comb begin
        dec_blank   = 1'b0;
        dec_illegal = 1'b0;
        dec_digit   = 4'hF;
        case (seg_in)
            7'b0000001: dec_digit = 4'd0;
            7'b1001111: dec_digit = 4'd1;
            7'b0010010: dec_digit = 4'd2;
            7'b0000110: dec_digit = 4'd3;
            7'b1001100: dec_digit = 4'd4;
            7'b0100100: dec_digit = 4'd5;
            7'b0100000: dec_digit = 4'd6;
            7'b0001111: dec_digit = 4'd7;
            7'b0000000: dec_digit = 4'd8;
            7'b0000100: dec_digit = 4'd9;
            7'b1111111: begin
                dec_digit = 4'hA;
                dec_blank = 1'b1;
            end
            default:    dec_illegal = 1'b1;
        endcase

        // Displayed value is operand+1: 0 wraps back to 15; blank covers
        // operands 9..14 so it reports the lowest, 9.
        if (dec_illegal) begin
            dec_orig = 4'hF;
        end else if (dec_blank) begin
            dec_orig = 4'd9;
        end else begin
            dec_orig = dec_digit - 4'd1;
        end
    end

    logic       same;
    logic [3:0] run_inc;

    always_comb begin
        state_d     = state_q;
        last_pat_d  = last_pat_q;
        run_d       = run_q;
        digit_d     = digit_q;
        orig_d      = orig_q;
        blank_d     = blank_q;
        illegal_d   = illegal_q;
        err_d       = err_q;
        out_valid_d = 1'b0;

        // In IDLE the stored pattern is the reset value and never counts as a match.
        same    = (state_q != IDLE) && (seg_in == last_pat_q);
        run_inc = (run_q >= STABLE) ? STABLE : run_q + 4'd1;

        if (seg_valid && !(state_q == LOCKED && same)) begin
            last_pat_d = seg_in;
            run_d      = same ? run_inc : 4'd1;
            state_d    = TRACK;
            // Holding off while out_valid is high keeps pulses apart when
            // STABLE_CNT=1; the run stays saturated and accepts on the next sample.
            if (run_d == STABLE && !out_valid_q) begin
                state_d     = LOCKED;
                out_valid_d = 1'b1;
                digit_d     = dec_digit;
                orig_d      = dec_orig;
                blank_d     = dec_blank;
                illegal_d   = dec_illegal;
                if (dec_illegal && err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_pat_q  <= 7'b1111111;
            run_q       <= 4'd0;
            digit_q     <= 4'hA;
            orig_q      <= 4'd9;
            blank_q     <= 1'b1;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            last_pat_q  <= last_pat_d;
            run_q       <= run_d;
            digit_q     <= digit_d;
            orig_q      <= orig_d;
            blank_q     <= blank_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign digit     = digit_q;
    assign orig      = orig_q;
    assign blank     = blank_q;
    assign illegal   = illegal_q;
    assign out_valid = out_valid_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_seg_reader.sv
module tb_seg_reader;

    localparam int STABLE_CNT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       seg_valid;
    logic [3:0] digit;
    logic [3:0] orig;
    logic       out_valid;
    logic       blank;
    logic       illegal;
    logic [7:0] err_count;

    seg_reader #(.STABLE_CNT(STABLE_CNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .digit     (digit),
        .orig      (orig),
        .out_valid (out_valid),
        .blank     (blank),
        .illegal   (illegal),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: history of valid samples since reset, plus the last
    // accepted decode. A pattern is accepted when its trailing streak reaches
    // exactly STABLE_CNT.
    logic [6:0] hist[$];
    logic [6:0] legal_tab[11] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100, 7'b1111111};
    int m_digit, m_orig, m_blank, m_illegal, m_err, m_ov;
    int pulses;
    logic prev_ov;

    function automatic int streak();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_digit = 10; m_orig = 9; m_blank = 1; m_illegal = 0; m_err = 0; m_ov = 0;
    endtask

    task automatic model_accept(input logic [6:0] p);
        int idx = -1;
        for (int i = 0; i < 11; i++) if (legal_tab[i] == p) idx = i;
        if (idx < 0) begin
            m_digit = 15; m_orig = 15; m_blank = 0; m_illegal = 1;
            if (m_err < 255) m_err++;
        end else if (idx == 10) begin
            m_digit = 10; m_orig = 9; m_blank = 1; m_illegal = 0;
        end else begin
            m_digit = idx; m_orig = (idx + 15) % 16; m_blank = 0; m_illegal = 0;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [6:0] p);
        @(negedge clk);
        rst = r; seg_valid = v; seg_in = p;
        @(posedge clk);
        #1;
        m_ov = 0;
        if (r) begin
            model_reset();
        end else if (v) begin
            hist.push_back(p);
            if (hist.size() > 20) void'(hist.pop_front());
            if (streak() == STABLE_CNT) begin
                m_ov = 1;
                model_accept(p);
            end
        end
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("digit",     32'(digit),     32'(m_digit));
        check("orig",      32'(orig),      32'(m_orig));
        check("blank",     32'(blank),     32'(m_blank));
        check("illegal",   32'(illegal),   32'(m_illegal));
        check("err_count", 32'(err_count), 32'(m_err));
        check("ov_twice",  32'(prev_ov && out_valid), 32'd0);
        prev_ov = out_valid;
        if (out_valid) pulses++;
    endtask

    task automatic samples(input int n, input logic [6:0] p);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, p);
    endtask

    initial begin
        rst = 1'b1; seg_valid = 1'b0; seg_in = 7'b1111111; prev_ov = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 7'b0);
        step(1'b1, 1'b1, 7'b0010010);   // reset dominates valid

        // Digit 2
        pulses = 0;
        samples(3, 7'b0010010);
        step(1'b0, 1'b0, 7'b0);
        check("p_dig2", 32'(pulses), 32'd1);

        // Digit 0 then blank
        pulses = 0;
        samples(3, 7'b0000001);
        samples(3, 7'b1111111);
        check("p_zero_blank", 32'(pulses), 32'd2);

        // Broken runs never accept
        pulses = 0;
        samples(2, 7'b0000110);
        samples(1, 7'b0100100);
        samples(2, 7'b0000110);
        check("p_broken", 32'(pulses), 32'd0);

        // Gaps in seg_valid do not break a run; locked pattern no longer pulses
        step(1'b1, 1'b0, 7'b0);
        pulses = 0;
        samples(1, 7'b0000110);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 7'b0100100);
        samples(2, 7'b0000110);
        check("p_gap", 32'(pulses), 32'd1);
        check("gap_digit", 32'(digit), 32'd3);
        check("gap_orig", 32'(orig), 32'd2);
        samples(10, 7'b0000110);
        check("p_locked", 32'(pulses), 32'd1);

        // Illegal pattern accepted 300 times; error count saturates
        for (int i = 0; i < 300; i++) begin
            samples(3, 7'b1111110);
            samples(3, 7'b0000000);
        end
        samples(3, 7'b1111110);
        check("err_sat", 32'(err_count), 32'd255);
        check("ill_digit", 32'(digit), 32'hF);

        // Reset mid-run discards the run
        samples(2, 7'b1001100);
        pulses = 0;
        step(1'b1, 1'b0, 7'b0);
        samples(1, 7'b1001100);
        check("p_rst_mid", 32'(pulses), 32'd0);
        check("rst_digit", 32'(digit), 32'hA);

        // Random mix of runs, gaps and occasional resets
        for (int r = 0; r < 400; r++) begin
            logic [6:0] pat;
            int len;
            case ($urandom_range(0, 7))
                0: pat = 7'b0010010;
                1: pat = 7'b0000001;
                2: pat = 7'b1111111;
                3: pat = 7'b1111110;
                4: pat = 7'b0000110;
                5: pat = 7'b0100100;
                6: pat = 7'($urandom);
                default: pat = 7'b0001111;
            endcase
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++)
                step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, pat);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
